// File: rtl/path_sched_ctrl_if.sv
// Signal bundle between the path scheduler and its environment: job config,
// epsilon stream, Path_Gen control/data and the terminal-price output stream.
interface path_sched_ctrl_if #(
    parameter int PATH_CNT_W = 16
);
    logic                  job_start;
    logic [PATH_CNT_W-1:0] num_paths;
    logic [11:0]           w_in;
    logic [11:0]           q_in;
    logic [11:0]           s0_in;

    logic [12:0]           eps_data;
    logic                  eps_valid;
    logic                  eps_ready;

    logic                  pg_start;
    logic [11:0]           pg_w;
    logic [11:0]           pg_q;
    logic [11:0]           pg_s0;
    logic [12:0]           pg_eps;
    logic                  pg_valid;
    logic [11:0]           pg_path;

    logic                  st_valid;
    logic                  st_ready;
    logic [11:0]           st_data;
    logic [PATH_CNT_W-1:0] st_idx;

    logic                  busy;
    logic                  done;

    // Controller side
    modport master (
        input  job_start, num_paths, w_in, q_in, s0_in,
        input  eps_data, eps_valid,
        output eps_ready,
        output pg_start, pg_w, pg_q, pg_s0, pg_eps,
        input  pg_valid, pg_path,
        output st_valid, st_data, st_idx,
        input  st_ready,
        output busy, done
    );

    // Environment side
    modport slave (
        output job_start, num_paths, w_in, q_in, s0_in,
        output eps_data, eps_valid,
        input  eps_ready,
        input  pg_start, pg_w, pg_q, pg_s0, pg_eps,
        output pg_valid, pg_path,
        input  st_valid, st_data, st_idx,
        output st_ready,
        input  busy, done
    );
endinterface

// File: rtl/path_sched_ctrl.sv
// Per-path sequencer for Path_Gen: buffers NUM_DAYS epsilons, launches the
// path, replays the buffer, and streams each terminal price downstream.
module path_sched_ctrl #(
    parameter int NUM_DAYS   = 8,
    parameter int PATH_CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    path_sched_ctrl_if.master bus
);
    localparam int DAY_W = (NUM_DAYS > 1) ? $clog2(NUM_DAYS) : 1;
    localparam logic [DAY_W-1:0] LAST_DAY = DAY_W'(NUM_DAYS - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FILL   = 3'd1,
        LAUNCH = 3'd2,
        RUN    = 3'd3,
        OUT    = 3'd4,
        DONE   = 3'd5
    } state_t;

    state_t state, state_nx;

    logic [11:0]           cfg_w;
    logic [11:0]           cfg_q;
    logic [11:0]           cfg_s0;
    logic [PATH_CNT_W-1:0] cfg_np;
    logic [PATH_CNT_W-1:0] path_idx;
    logic [DAY_W-1:0]      fill_cnt;
    logic [DAY_W-1:0]      rd_cnt;
    logic                  rd_active;
    logic [DAY_W-1:0]      vld_cnt;
    logic [11:0]           st_data_q;
    logic                  zero_done;
    logic [12:0]           eps_buf [NUM_DAYS];

    logic accept;
    logic last_pulse;
    logic handshake;
    logic last_path;
    logic job_go;

    always_comb begin
        job_go     = (state == IDLE) && bus.job_start;
        accept     = (state == FILL) && bus.eps_valid;
        last_pulse = (state == RUN) && bus.pg_valid && (vld_cnt == LAST_DAY);
        handshake  = (state == OUT) && bus.st_ready;
        last_path  = (path_idx == cfg_np - 1'b1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:   if (job_go && (bus.num_paths != '0)) state_nx = FILL;
            FILL:   if (accept && (fill_cnt == LAST_DAY)) state_nx = LAUNCH;
            LAUNCH: state_nx = RUN;
            RUN:    if (last_pulse) state_nx = OUT;
            OUT:    if (handshake) state_nx = last_path ? DONE : FILL;
            DONE:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        bus.eps_ready = (state == FILL);
        bus.pg_start  = (state == LAUNCH);
        bus.pg_eps    = '0;
        if ((state == RUN) && rd_active) begin
            bus.pg_eps = eps_buf[rd_cnt];
        end
        bus.pg_w     = cfg_w;
        bus.pg_q     = cfg_q;
        bus.pg_s0    = cfg_s0;
        bus.st_valid = (state == OUT);
        bus.st_data  = st_data_q;
        bus.st_idx   = path_idx;
        bus.busy     = (state != IDLE);
        bus.done     = (state == DONE) || zero_done;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_w     <= '0;
            cfg_q     <= '0;
            cfg_s0    <= '0;
            cfg_np    <= '0;
            zero_done <= 1'b0;
        end else begin
            zero_done <= job_go && (bus.num_paths == '0);
            if (job_go) begin
                cfg_w  <= bus.w_in;
                cfg_q  <= bus.q_in;
                cfg_s0 <= bus.s0_in;
                cfg_np <= bus.num_paths;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_cnt <= '0;
            for (int unsigned i = 0; i < NUM_DAYS; i++) begin
                eps_buf[i] <= '0;
            end
        end else if (accept) begin
            eps_buf[fill_cnt] <= bus.eps_data;
            fill_cnt          <= (fill_cnt == LAST_DAY) ? '0 : fill_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            path_idx <= '0;
        end else if (job_go) begin
            path_idx <= '0;
        end else if (handshake && !last_path) begin
            path_idx <= path_idx + 1'b1;
        end
    end

    // Replay pointer runs from the cycle after pg_start; pulse counter tracks
    // Path_Gen outputs independently so its latency is not hard-coded here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_cnt    <= '0;
            rd_active <= 1'b0;
            vld_cnt   <= '0;
            st_data_q <= '0;
        end else begin
            if (state == LAUNCH) begin
                rd_cnt    <= '0;
                rd_active <= 1'b1;
                vld_cnt   <= '0;
            end else if (state == RUN) begin
                if (rd_active) begin
                    rd_cnt    <= (rd_cnt == LAST_DAY) ? '0 : rd_cnt + 1'b1;
                    rd_active <= (rd_cnt != LAST_DAY);
                end
                if (bus.pg_valid) begin
                    vld_cnt <= (vld_cnt == LAST_DAY) ? '0 : vld_cnt + 1'b1;
                end
                if (last_pulse) begin
                    st_data_q <= bus.pg_path;
                end
            end else begin
                rd_active <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_path_sched_ctrl.sv
// Directed bench for path_sched_ctrl with a behavioural Path_Gen stub that
// emits 0x100+day for days 0..7 on cycles s+4..s+11 after pg_start.
module tb_path_sched_ctrl;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    path_sched_ctrl_if #(.PATH_CNT_W(16)) bus ();

    path_sched_ctrl #(
        .NUM_DAYS  (8),
        .PATH_CNT_W(16)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Path_Gen stub: sc counts cycles since pg_start
    logic [3:0] sc;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) sc <= 4'd0;
        else if (bus.pg_start) sc <= 4'd1;
        else if (sc != 4'd0 && sc != 4'd11) sc <= sc + 4'd1;
        else sc <= 4'd0;
    end
    assign bus.pg_valid = (sc >= 4'd4) && (sc <= 4'd11);
    assign bus.pg_path  = 12'h0FC + 12'(sc);

    typedef struct {
        logic        js;
        logic        ev;
        logic [12:0] ed;
        logic        sr;
        logic        er;
        logic        ps;
        logic [12:0] pe;
        logic        sv;
        logic [11:0] sd;
        logic        bz;
        logic        dn;
    } vec_t;

    vec_t        tbl [24];
    logic [12:0] samp [8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic start_job(input logic [15:0] np, input logic [11:0] w,
                             input logic [11:0] q, input logic [11:0] s0);
        bus.num_paths = np;
        bus.w_in      = w;
        bus.q_in      = q;
        bus.s0_in     = s0;
        bus.job_start = 1'b1;
        tick();
        bus.job_start = 1'b0;
    endtask

    task automatic fill_path();
        for (int d = 0; d < 8; d++) begin
            chk("fill_ready", bus.eps_ready, 1);
            bus.eps_valid = 1'b1;
            bus.eps_data  = samp[d];
            tick();
        end
        bus.eps_valid = 1'b0;
        bus.eps_data  = '0;
    endtask

    task automatic wait_st();
        int n;
        n = 0;
        while (!bus.st_valid && n < 30) begin
            tick();
            n++;
        end
        chk("st_valid_wait", bus.st_valid, 1);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        for (int d = 0; d < 8; d++) begin
            samp[d] = 13'(13'h0F0 + d * 13'h111) | ((d % 2 == 1) ? 13'h1000 : 13'h0);
        end

        // Single-path trace, one row per cycle starting at the job_start cycle
        tbl[0] = '{1'b1, 1'b0, 13'h0, 1'b0, 1'b0, 1'b0, 13'h0, 1'b0, 12'h000, 1'b0, 1'b0};
        for (int i = 1; i <= 8; i++)
            tbl[i] = '{1'b0, 1'b1, 13'(i), 1'b0, 1'b1, 1'b0, 13'h0, 1'b0, 12'h000, 1'b1, 1'b0};
        tbl[9] = '{1'b0, 1'b0, 13'h0, 1'b0, 1'b0, 1'b1, 13'h0, 1'b0, 12'h000, 1'b1, 1'b0};
        for (int i = 10; i <= 17; i++)
            tbl[i] = '{1'b0, 1'b0, 13'h0, 1'b0, 1'b0, 1'b0, 13'(i - 9), 1'b0, 12'h000, 1'b1, 1'b0};
        for (int i = 18; i <= 20; i++)
            tbl[i] = '{1'b0, 1'b0, 13'h0, 1'b0, 1'b0, 1'b0, 13'h0, 1'b0, 12'h000, 1'b1, 1'b0};
        tbl[21] = '{1'b0, 1'b0, 13'h0, 1'b1, 1'b0, 1'b0, 13'h0, 1'b1, 12'h107, 1'b1, 1'b0};
        tbl[22] = '{1'b0, 1'b0, 13'h0, 1'b0, 1'b0, 1'b0, 13'h0, 1'b0, 12'h107, 1'b1, 1'b1};
        tbl[23] = '{1'b0, 1'b0, 13'h0, 1'b0, 1'b0, 1'b0, 13'h0, 1'b0, 12'h107, 1'b0, 1'b0};

        rst_n         = 1'b0;
        bus.job_start = 1'b0;
        bus.num_paths = '0;
        bus.w_in      = '0;
        bus.q_in      = '0;
        bus.s0_in     = '0;
        bus.eps_valid = 1'b0;
        bus.eps_data  = '0;
        bus.st_ready  = 1'b0;
        tick();
        tick();
        chk("reset_outs", {bus.eps_ready, bus.pg_start, bus.pg_eps, bus.st_valid,
                           bus.busy, bus.done}, 0);
        chk("reset_data", {bus.st_data, bus.pg_w, bus.pg_q, bus.pg_s0}, 0);
        chk("reset_idx", 32'(bus.st_idx), 0);
        rst_n = 1'b1;
        tick();

        // Table-driven single path
        bus.num_paths = 16'd1;
        bus.w_in      = 12'h123;
        bus.q_in      = 12'h456;
        bus.s0_in     = 12'h789;
        for (int i = 0; i < 24; i++) begin
            bus.job_start = tbl[i].js;
            bus.eps_valid = tbl[i].ev;
            bus.eps_data  = tbl[i].ed;
            bus.st_ready  = tbl[i].sr;
            chk($sformatf("vec[%0d]", i),
                32'({bus.eps_ready, bus.pg_start, bus.pg_eps, bus.st_valid,
                     bus.st_data, bus.busy, bus.done}),
                32'({tbl[i].er, tbl[i].ps, tbl[i].pe, tbl[i].sv,
                     tbl[i].sd, tbl[i].bz, tbl[i].dn}));
            tick();
        end
        bus.job_start = 1'b0;
        bus.eps_valid = 1'b0;
        bus.st_ready  = 1'b0;
        chk("cfg_hold", {bus.pg_w, bus.pg_q, bus.pg_s0}, {12'h123, 12'h456, 12'h789});

        // Epsilon stall: eps_valid toggles, garbage on idle cycles
        begin
            int  k;
            int  n;
            logic evt;
            logic acc;
            start_job(16'd1, 12'h0AA, 12'h0BB, 12'h0CC);
            k   = 0;
            n   = 0;
            evt = 1'b1;
            while (k < 8 && n < 40) begin
                bus.eps_valid = evt;
                bus.eps_data  = evt ? samp[k] : 13'h1FFF;
                chk("stall_no_start", bus.pg_start, 0);
                chk("stall_ready", bus.eps_ready, 1);
                acc = evt && bus.eps_ready;
                tick();
                if (acc) k++;
                evt = !evt;
                n++;
            end
            bus.eps_valid = 1'b0;
            chk("stall_accepts", 32'(k), 8);
            chk("stall_launch", bus.pg_start, 1);
            chk("stall_ready_off", bus.eps_ready, 0);
            for (int d = 0; d < 8; d++) begin
                tick();
                chk($sformatf("stall_eps[%0d]", d), 32'(bus.pg_eps), 32'(samp[d]));
            end
            tick();
            chk("stall_eps_end", 32'(bus.pg_eps), 0);
            wait_st();
            chk("stall_st_data", 32'(bus.st_data), 32'h107);
            bus.st_ready = 1'b1;
            tick();
            bus.st_ready = 1'b0;
            chk("stall_done", bus.done, 1);
            tick();
            chk("stall_idle", {bus.busy, bus.done}, 0);
        end

        // Output backpressure over 3 paths, with a job_start during RUN of path 1
        start_job(16'd3, 12'h321, 12'h654, 12'h0FE);
        for (int p = 0; p < 3; p++) begin
            fill_path();
            chk("bp_launch", bus.pg_start, 1);
            if (p == 1) begin
                tick();
                bus.job_start = 1'b1;
                bus.w_in      = 12'h7FF;
                bus.num_paths = 16'd1;
                tick();
                bus.job_start = 1'b0;
                bus.w_in      = 12'h321;
                chk("busy_js_pg_w", 32'(bus.pg_w), 32'h321);
            end
            wait_st();
            for (int c = 0; c < 5; c++) begin
                chk("bp_hold_valid", bus.st_valid, 1);
                chk("bp_hold_data", 32'(bus.st_data), 32'h107);
                chk("bp_hold_idx", 32'(bus.st_idx), 32'(p));
                chk("bp_no_fill", {bus.eps_ready, bus.pg_start}, 0);
                tick();
            end
            bus.st_ready = 1'b1;
            tick();
            bus.st_ready = 1'b0;
            if (p < 2) begin
                chk("bp_next_fill", {bus.eps_ready, bus.done}, 2'b10);
            end else begin
                chk("bp_done", {bus.eps_ready, bus.st_valid, bus.done}, 3'b001);
            end
        end
        tick();
        chk("bp_idle", {bus.busy, bus.done}, 0);

        // num_paths == 0
        bus.num_paths = 16'd0;
        bus.job_start = 1'b1;
        chk("zero_busy_pre", bus.busy, 0);
        tick();
        bus.job_start = 1'b0;
        chk("zero_done", {bus.done, bus.busy, bus.eps_ready, bus.pg_start}, 4'b1000);
        tick();
        chk("zero_after", {bus.done, bus.busy, bus.eps_ready, bus.pg_start}, 0);

        // Reset during RUN at s+4
        begin
            int n;
            start_job(16'd2, 12'h111, 12'h222, 12'h333);
            fill_path();
            n = 0;
            while (!bus.pg_start && n < 5) begin
                tick();
                n++;
            end
            chk("rst_launch", bus.pg_start, 1);
            repeat (4) tick();
            chk("rst_pre_eps", 32'(bus.pg_eps), 32'(samp[3]));
            rst_n = 1'b0;
            #1;
            chk("rst_outs", {bus.eps_ready, bus.pg_start, bus.pg_eps, bus.st_valid,
                             bus.busy, bus.done}, 0);
            chk("rst_data", {bus.st_data, bus.pg_w, bus.pg_q, bus.pg_s0}, 0);
            chk("rst_idx", 32'(bus.st_idx), 0);
            tick();
            rst_n = 1'b1;
            tick();
            chk("rst_idle", bus.busy, 0);
            start_job(16'd1, 12'h444, 12'h555, 12'h666);
            fill_path();
            wait_st();
            chk("rst_job_data", {bus.st_data, 16'(bus.st_idx)}, {12'h107, 16'h0});
            bus.st_ready = 1'b1;
            tick();
            bus.st_ready = 1'b0;
            chk("rst_job_done", bus.done, 1);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
